// File: rtl/sw_outarb.sv
// Per-output round-robin packet arbiter: grants one input for a whole packet
// (head..tail) and releases on tail, or forcibly at MAXLEN with an err pulse.
module sw_outarb #(
  parameter int NPORT  = 4,
  parameter int MAXLEN = 16,
  parameter int LW     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] valid,
  input  logic [NPORT-1:0] tail,
  input  logic             out_ready,
  output logic [NPORT-1:0] ack,
  output logic             out_valid,
  output logic             fire,
  output logic             err
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [NPORT-1:0] ack_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [LW-1:0]    len, len_nxt, len_inc;
  logic             err_nxt;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic             owner_tail;
  logic             at_max;

  // Handshake: a flit moves on a cycle where the owner's valid and out_ready
  // are both high (fire); neither side may depend on the other combinationally.
  assign out_valid  = |(ack & valid);
  assign owner_tail = |(ack & valid & tail);
  assign fire       = out_valid & out_ready;
  assign len_inc    = len + LW'(1);
  assign at_max     = (len_inc == LW'(MAXLEN));

  // Round-robin search starting at ptr, wrapping modulo NPORT.
  always_comb begin : win_search
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NPORT; k++) begin
      cand = (int'(ptr) + k) % NPORT;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = ack;
    ptr_nxt   = ptr;
    len_nxt   = len;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        ack_nxt = '0;
        if (win_found) begin
          ack_nxt[win_idx] = 1'b1;
          ptr_nxt          = PW'((int'(win_idx) + 1) % NPORT);
          len_nxt          = '0;
          state_nxt        = BUSY;
        end
      end
      BUSY: begin
        if (fire) begin
          len_nxt = len_inc;
          if (owner_tail || at_max) begin
            ack_nxt   = '0;
            len_nxt   = '0;
            err_nxt   = !owner_tail;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        ack_nxt   = '0;
        len_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ack   <= '0;
      ptr   <= '0;
      len   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      ack   <= ack_nxt;
      ptr   <= ptr_nxt;
      len   <= len_nxt;
      err   <= err_nxt;
    end
  end

endmodule
